// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared types, constants and segment decode for the display scheduler
package disp_pkg;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_OUT  = 2'd1,
    SRC_FP   = 2'd2,
    SRC_PC   = 2'd3
  } disp_src_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_LOAD,
    ST_DWELL
  } disp_state_t;

  localparam logic [6:0]  SEG_DASH  = 7'b0111111;
  localparam logic [7:0]  SEG_BLANK = 8'hFF;
  localparam logic [31:0] MAX_DISP  = 32'd9999;
  localparam logic [3:0]  CODE_DASH = 4'hA;

  // Active-low {g..a}; CODE_DASH yields the dash, any other non-BCD code is dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'd0:      pat = 7'b1000000;
      4'd1:      pat = 7'b1111001;
      4'd2:      pat = 7'b0100100;
      4'd3:      pat = 7'b0110000;
      4'd4:      pat = 7'b0011001;
      4'd5:      pat = 7'b0010010;
      4'd6:      pat = 7'b0000010;
      4'd7:      pat = 7'b1111000;
      4'd8:      pat = 7'b0000000;
      4'd9:      pat = 7'b0010000;
      CODE_DASH: pat = SEG_DASH;
      default:   pat = 7'b1111111;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - iterative double-dabble, 14-bit binary to 4-digit BCD in 14 cycles
module bin2bcd_seq
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] bin,
  output logic [15:0] bcd,
  output logic        done
);

  localparam logic [3:0] STEPS = 4'd14;

  logic [13:0] shreg;
  logic [3:0]  cnt;
  logic [15:0] adj;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
    end
  end

  // done marks the cycle whose edge performs the final shift; bcd is valid right after it.
  assign done = (cnt == 4'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= '0;
      bcd   <= '0;
      cnt   <= '0;
    end else if (start) begin
      shreg <= bin;
      bcd   <= '0;
      cnt   <= STEPS;
    end else if (cnt != 4'd0) begin
      bcd   <= {adj[14:0], shreg[13]};
      shreg <= {shreg[12:0], 1'b0};
      cnt   <= cnt - 4'd1;
    end
  end

endmodule

// File: rtl/disp_scan_arbiter.sv
// rtl/disp_scan_arbiter.sv - display request arbiter, BCD loader and 4-digit scanner
// Optional build macro: DISP_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module disp_scan_arbiter
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV  = 208333,
  parameter int DWELL_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] out_val,
  input  logic        out_req,
  input  logic [31:0] fp_val,
  input  logic        fp_req,
  input  logic [9:0]  pc_val,
  input  logic        pc_req,
  input  logic        halt,
  output logic [2:0]  grant,
  output logic        busy,
  output logic [1:0]  cur_src,
  output logic [7:0]  seg,
  output logic [3:0]  dig
);

  localparam int RW = $clog2(REFRESH_DIV + 1);
  localparam int DW = $clog2(DWELL_CYCLES + 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] DWELL_LAST   = DW'(DWELL_CYCLES - 1);

  disp_state_t     state, state_nxt;
  disp_src_t       src_sel, pend_src, cur_src_q;
  logic [31:0]     sel_val;
  logic            sel_ovf, pend_ovf;
  logic [2:0]      grant_nxt;
  logic            conv_start, conv_done;
  logic [15:0]     conv_bcd;
  logic [DW-1:0]   dwell_cnt;
  logic [3:0][3:0] digit_buf;
  logic [RW-1:0]   refresh_cnt;
  logic [1:0]      digit_sel;
  logic [3:0]      lead_zero;
  logic [7:0]      seg_nxt;

  assign cur_src = cur_src_q;

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (sel_val[13:0]),
    .bcd   (conv_bcd),
    .done  (conv_done)
  );

  // src_sel != SRC_NONE is the single point where a request is accepted.
  always_comb begin
    state_nxt = state;
    src_sel   = SRC_NONE;
    sel_val   = '0;
    grant_nxt = '0;
    case (state)
      ST_IDLE: begin
        if (!halt) begin
          if (out_req)     src_sel = SRC_OUT;
          else if (fp_req) src_sel = SRC_FP;
          else if (pc_req) src_sel = SRC_PC;
        end
      end
      ST_CONV: begin
        if (pend_ovf || conv_done) state_nxt = ST_LOAD;
      end
      ST_LOAD: state_nxt = ST_DWELL;
      ST_DWELL: begin
        if (!halt && out_req && cur_src_q != SRC_OUT) begin
          src_sel = SRC_OUT;
        end else if (dwell_cnt == DWELL_LAST) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    case (src_sel)
      SRC_OUT: begin sel_val = out_val;          grant_nxt = 3'b001; end
      SRC_FP:  begin sel_val = fp_val;           grant_nxt = 3'b010; end
      SRC_PC:  begin sel_val = {22'd0, pc_val};  grant_nxt = 3'b100; end
      default: ;
    endcase

    if (src_sel != SRC_NONE) state_nxt = ST_CONV;
    sel_ovf    = (sel_val > MAX_DISP);
    conv_start = (src_sel != SRC_NONE) && !sel_ovf;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      grant     <= '0;
      busy      <= 1'b0;
      pend_src  <= SRC_NONE;
      pend_ovf  <= 1'b0;
      cur_src_q <= SRC_NONE;
      dwell_cnt <= '0;
      digit_buf <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      if (src_sel != SRC_NONE) begin
        busy     <= 1'b1;
        pend_src <= src_sel;
        pend_ovf <= sel_ovf;
      end else if (state == ST_LOAD) begin
        busy <= 1'b0;
      end
      if (state == ST_LOAD) begin
        digit_buf <= pend_ovf ? {4{CODE_DASH}} : conv_bcd;
        cur_src_q <= pend_src;
        dwell_cnt <= '0;
      end else if (state == ST_DWELL) begin
        dwell_cnt <= dwell_cnt + DW'(1);
      end
    end
  end

  // lead_zero[i] means digit i and everything above it are zero; digit 0 is never blanked.
  always_comb begin
`ifdef DISP_LEADING_ZERO_BLANK_EN
    lead_zero[0] = 1'b0;
    lead_zero[3] = (digit_buf[3] == 4'd0);
    lead_zero[2] = lead_zero[3] && (digit_buf[2] == 4'd0);
    lead_zero[1] = lead_zero[2] && (digit_buf[1] == 4'd0);
`else
    lead_zero = '0;
`endif
    if (halt)                      seg_nxt = {1'b1, SEG_DASH};
    else if (lead_zero[digit_sel]) seg_nxt = SEG_BLANK;
    else                           seg_nxt = {1'b1, seg_decode(digit_buf[digit_sel])};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt <= '0;
      digit_sel   <= '0;
      dig         <= 4'hF;
      seg         <= 8'hFF;
    end else begin
      if (refresh_cnt == REFRESH_LAST) begin
        refresh_cnt <= '0;
        digit_sel   <= digit_sel + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + RW'(1);
      end
      dig <= ~(4'b0001 << digit_sel);
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_disp_scan_arbiter.sv
// tb/tb_disp_scan_arbiter.sv - scoreboard bench for disp_scan_arbiter
module tb_disp_scan_arbiter;

  localparam int REFRESH_DIV  = 4;
  localparam int DWELL_CYCLES = 40;
  localparam logic [7:0] SEG_TBL [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  localparam logic [31:0] DASHES = 32'hBFBFBFBF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] out_val = '0;
  logic [31:0] fp_val = '0;
  logic [9:0]  pc_val = '0;
  logic        out_req = 1'b0, fp_req = 1'b0, pc_req = 1'b0, halt = 1'b0;
  logic [2:0]  grant;
  logic        busy;
  logic [1:0]  cur_src;
  logic [7:0]  seg;
  logic [3:0]  dig;

  typedef struct packed {
    logic [2:0]  gnt;
    logic [1:0]  src;
    logic [31:0] segs;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  disp_scan_arbiter #(.REFRESH_DIV(REFRESH_DIV), .DWELL_CYCLES(DWELL_CYCLES)) dut (
    .clk(clk), .reset(reset),
    .out_val(out_val), .out_req(out_req),
    .fp_val(fp_val), .fp_req(fp_req),
    .pc_val(pc_val), .pc_req(pc_req),
    .halt(halt), .grant(grant), .busy(busy), .cur_src(cur_src),
    .seg(seg), .dig(dig)
  );

  function automatic logic [31:0] model(input int unsigned v);
    logic [31:0] r;
    int unsigned x;
`ifdef DISP_LEADING_ZERO_BLANK_EN
    int unsigned pw;
`endif
    if (v > 9999) return DASHES;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[i*8 +: 8] = SEG_TBL[x % 10];
      x = x / 10;
    end
`ifdef DISP_LEADING_ZERO_BLANK_EN
    pw = 10;
    for (int i = 1; i < 4; i++) begin
      if (v < pw) r[i*8 +: 8] = 8'hFF;
      pw = pw * 10;
    end
`endif
    return r;
  endfunction

  function automatic int dig_idx(input logic [3:0] d);
    case (d)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic request(input int src, input int unsigned v);
    exp_t e;
    e.src  = 2'(src);
    e.gnt  = 3'(1 << (src - 1));
    e.segs = model(v);
    case (src)
      1: begin out_val = v;      out_req = 1'b1; end
      2: begin fp_val = v;       fp_req = 1'b1;  end
      default: begin pc_val = 10'(v); pc_req = 1'b1; end
    endcase
    sb.push_back(e);
  endtask

  task automatic take_grant();
    chk("sb_pending", 32'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      chk("grant", 32'(grant), 32'(cur.gnt));
    end
    if (grant[0]) out_req = 1'b0;
    if (grant[1]) fp_req = 1'b0;
    if (grant[2]) pc_req = 1'b0;
  endtask

  task automatic wait_grant(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (grant == 3'b000 && lat < 400);
    take_grant();
  endtask

  task automatic wait_busy(output int n);
    int extra;
    n = 0;
    extra = 0;
    do begin
      @(negedge clk);
      n++;
      if (grant != 3'b000) extra++;
    end while (busy === 1'b1 && n < 100);
    chk("busy_fall", 32'(busy), 0);
    chk("grant_pulse", extra, 0);
  endtask

  task automatic sample_scan(input string tag, input logic [31:0] want, input int ncyc);
    logic [3:0] seen;
    int k;
    seen = '0;
    repeat (ncyc) begin
      @(negedge clk);
      k = dig_idx(dig);
      if (k >= 0 && !seen[k]) begin
        seen[k] = 1'b1;
        chk(tag, 32'(seg), 32'(want[k*8 +: 8]));
      end
    end
    chk({tag, "_cover"}, 32'(seen), 32'hF);
  endtask

  initial begin
    int lat, n, gcount, k;
    logic [3:0]  seen;
    logic [31:0] want56;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_dig", 32'(dig), 32'hF);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_src", 32'(cur_src), 0);
    reset = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      if (i == 1)  begin chk("dig_first", 32'(dig), 32'hE); chk("seg_first", 32'(seg), 32'hC0); end
      if (i == 5)  chk("dig_slot1", 32'(dig), 32'hD);
      if (i == 9)  chk("dig_slot2", 32'(dig), 32'hB);
      if (i == 13) chk("dig_slot3", 32'(dig), 32'h7);
      if (i == 17) chk("dig_wrap", 32'(dig), 32'hE);
    end

    request(1, 1234);
    wait_grant(lat);
    chk("grant_lat", lat, 1);
    chk("busy_at_grant", 32'(busy), 1);
    wait_busy(n);
    chk("busy_lat", n, 15);
    chk("src_1234", 32'(cur_src), 32'(cur.src));
    sample_scan("scan_1234", cur.segs, 20);

    repeat (30) @(negedge clk);
    request(1, 42);
    request(2, 805);
    request(3, 987);
    for (int j = 0; j < 3; j++) begin
      wait_grant(lat);
      if (j == 0) chk("multi_lat", lat, 1);
      wait_busy(n);
      chk("multi_busy_lat", n, 15);
      chk("multi_src", 32'(cur_src), 32'(cur.src));
      sample_scan("scan_multi", cur.segs, 20);
    end

    request(1, 7);
    wait_grant(lat);
    chk("preempt_lat", lat, 1);
    wait_busy(n);
    chk("src_7", 32'(cur_src), 1);
    sample_scan("scan_7", cur.segs, 20);

    request(2, 12345);
    wait_grant(lat);
    wait_busy(n);
    chk("ovf_lat", n, 2);
    chk("src_ovf", 32'(cur_src), 2);
    sample_scan("scan_ovf", cur.segs, 20);

    request(1, 56);
    wait_grant(lat);
    chk("preempt56_lat", lat, 1);
    halt = 1'b1;
    request(3, 300);
    wait_busy(n);
    chk("halt_conv_lat", n, 15);
    chk("src_56", 32'(cur_src), 1);
    sample_scan("scan_halt", DASHES, 20);
    gcount = 0;
    repeat (60) begin
      @(negedge clk);
      if (grant != 3'b000) gcount++;
    end
    chk("halt_no_grant", gcount, 0);
    want56 = model(56);
    halt = 1'b0;
    lat = 0;
    seen = '0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (grant != 3'b000 && lat == 0) begin
        lat = i;
        take_grant();
      end
      k = dig_idx(dig);
      if (k >= 0 && !seen[k]) begin
        seen[k] = 1'b1;
        chk("scan_resume", 32'(seg), 32'(want56[k*8 +: 8]));
      end
    end
    chk("resume_grant_lat", lat, 1);
    wait_busy(n);
    chk("src_pc", 32'(cur_src), 3);
    sample_scan("scan_300", cur.segs, 20);

    request(1, 4321);
    wait_grant(lat);
    chk("preempt4321_lat", lat, 1);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_src", 32'(cur_src), 0);
    chk("abort_seg", 32'(seg), 32'hFF);
    chk("abort_dig", 32'(dig), 32'hF);
    chk("abort_grant", 32'(grant), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_dig0", 32'(dig), 32'hE);
    chk("abort_buf0", 32'(seg), 32'hC0);
    gcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (grant != 3'b000 || busy !== 1'b0) gcount++;
    end
    chk("abort_quiet", gcount, 0);

    request(1, 9999);
    wait_grant(lat);
    chk("max_lat", lat, 1);
    wait_busy(n);
    chk("max_busy_lat", n, 15);
    chk("src_9999", 32'(cur_src), 1);
    sample_scan("scan_9999", cur.segs, 20);

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
